// File: rtl/dma_axi_mchan_pkg.sv
// Shared types for the multi-channel AXI4 DMA: bus typedefs, descriptor struct, FSM states.
package dma_axi_mchan_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
    typedef logic [AXI_DATA_W-1:0] axi_data_t;
    typedef logic [AXI_ID_W-1:0]   axi_id_t;

    localparam int unsigned AXI_BW_BYTES = $bits(axi_data_t) / 8;
    localparam int unsigned AXI_SIZE_LOG = $clog2(AXI_BW_BYTES);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_RD,
        ST_AW,
        ST_WR,
        ST_B
    } dma_st_t;

    typedef struct packed {
        axi_addr_t   src;
        axi_addr_t   dst;
        logic [31:0] remaining;
    } dma_ch_desc_t;

    typedef struct packed {
        axi_id_t             awid;
        axi_addr_t           awaddr;
        logic [7:0]          awlen;
        logic [2:0]          awsize;
        logic [1:0]          awburst;
        logic                awlock;
        logic [3:0]          awcache;
        logic [2:0]          awprot;
        logic [3:0]          awqos;
        logic [3:0]          awregion;
        logic                awuser;
        logic                awvalid;
        axi_data_t           wdata;
        logic [AXI_STRB_W-1:0] wstrb;
        logic                wlast;
        logic                wuser;
        logic                wvalid;
        logic                bready;
        axi_id_t             arid;
        axi_addr_t           araddr;
        logic [7:0]          arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
        logic                arlock;
        logic [3:0]          arcache;
        logic [2:0]          arprot;
        logic [3:0]          arqos;
        logic [3:0]          arregion;
        logic                aruser;
        logic                arvalid;
        logic                rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        axi_id_t    bid;
        logic [1:0] bresp;
        logic       buser;
        logic       bvalid;
        logic       arready;
        axi_id_t    rid;
        axi_data_t  rdata;
        logic [1:0] rresp;
        logic       rlast;
        logic       ruser;
        logic       rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/dma_axi_mchan_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and a synchronous clear.
module dma_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [PW:0]      cnt;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                wp <= (wp == PW'(DEPTH-1)) ? '0 : wp + 1'b1;
            end
            if (do_pop) begin
                rp <= (rp == PW'(DEPTH-1)) ? '0 : rp + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dma_axi_mchan.sv
// Multi-channel AXI4 mem-to-mem DMA, round-robin per burst over one master port.
// Optional DMA_4K_SPLIT_EN limits every burst to a single 4KB page on src and dst.
module dma_axi_mchan
    import dma_axi_mchan_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_start_i,
    input  axi_addr_t [NUM_CH-1:0]      ch_src_i,
    input  axi_addr_t [NUM_CH-1:0]      ch_dst_i,
    input  logic [NUM_CH-1:0][31:0]     ch_bytes_i,
    output logic [NUM_CH-1:0]           ch_busy_o,
    output logic [NUM_CH-1:0]           ch_done_o,
    output logic [NUM_CH-1:0]           ch_error_o,
    output s_axi_mosi_t                 dma_m_mosi_o,
    input  s_axi_miso_t                 dma_m_miso_i
);

    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam axi_addr_t   ALIGN_MSK = axi_addr_t'(AXI_BW_BYTES - 1);

    dma_st_t          state;
    dma_ch_desc_t     desc [NUM_CH];
    logic [NUM_CH-1:0] busy, done_q, error_q;
    logic [CH_W-1:0]  rr_ptr, grant, grant_q, rr_next;
    logic [8:0]       beats_nxt, beats_q, wr_cnt;
    logic [31:0]      step;
    logic             rd_err;
    logic             arvalid, awvalid, rready_q, bready;
    axi_addr_t        araddr, awaddr;
    logic [7:0]       axlen;
    axi_id_t          axid;

    logic             fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    axi_data_t        fifo_dout;
    logic             rready, wvalid, wlast, rd_fail;
    logic             unused_resp;

    assign unused_resp = ^{dma_m_miso_i.bid, dma_m_miso_i.buser,
                           dma_m_miso_i.rid, dma_m_miso_i.ruser};

    always_comb begin
        logic        found;
        int unsigned idx;
        found = 1'b0;
        idx   = 0;
        grant = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_CH;
            if (!found && busy[idx]) begin
                grant = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        logic [31:0] words;
`ifdef DMA_4K_SPLIT_EN
        logic [12:0] src_room, dst_room;
`endif
        words     = desc[grant].remaining >> AXI_SIZE_LOG;
        beats_nxt = (words > 32'(MAX_BEATS)) ? 9'(MAX_BEATS) : words[8:0];
`ifdef DMA_4K_SPLIT_EN
        src_room = (13'h1000 - {1'b0, desc[grant].src[11:0]}) >> AXI_SIZE_LOG;
        dst_room = (13'h1000 - {1'b0, desc[grant].dst[11:0]}) >> AXI_SIZE_LOG;
        if ({4'b0, beats_nxt} > src_room) beats_nxt = src_room[8:0];
        if ({4'b0, beats_nxt} > dst_room) beats_nxt = dst_room[8:0];
`endif
    end

    assign step      = 32'(beats_q) << AXI_SIZE_LOG;
    assign rr_next   = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(grant_q + 1'b1);
    assign rready    = rready_q & ~fifo_full;
    assign wvalid    = (state == ST_WR) & ~fifo_empty;
    assign wlast     = (wr_cnt == beats_q - 9'd1);
    assign fifo_push = (state == ST_RD) & rready & dma_m_miso_i.rvalid;
    assign fifo_pop  = wvalid & dma_m_miso_i.wready;
    assign rd_fail   = rd_err | (dma_m_miso_i.rresp != AXI_RESP_OKAY);
    // A failed burst never reaches the write phase, so its buffered beats are dropped here.
    assign fifo_clr  = fifo_push & dma_m_miso_i.rlast & rd_fail;

    dma_fifo #(
        .WIDTH(AXI_DATA_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .clr  (fifo_clr),
        .push (fifo_push),
        .din  (dma_m_miso_i.rdata),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= '0;
            done_q   <= '0;
            error_q  <= '0;
            rr_ptr   <= '0;
            grant_q  <= '0;
            beats_q  <= '0;
            wr_cnt   <= '0;
            rd_err   <= 1'b0;
            arvalid  <= 1'b0;
            awvalid  <= 1'b0;
            rready_q <= 1'b0;
            bready   <= 1'b0;
            araddr   <= '0;
            awaddr   <= '0;
            axlen    <= '0;
            axid     <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                desc[c] <= '0;
            end
        end else begin
            done_q  <= '0;
            error_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_start_i[c] && !busy[c]) begin
                    desc[c] <= '{src: ch_src_i[c], dst: ch_dst_i[c], remaining: ch_bytes_i[c]};
                    if (ch_bytes_i[c] == '0) begin
                        done_q[c] <= 1'b1;
                    end else if (((ch_bytes_i[c] | ch_src_i[c] | ch_dst_i[c]) & ALIGN_MSK) != '0) begin
                        error_q[c] <= 1'b1;
                    end else begin
                        busy[c] <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|busy) begin
                        grant_q <= grant;
                        beats_q <= beats_nxt;
                        axid    <= AXI_ID_W'(grant);
                        axlen   <= 8'(beats_nxt - 9'd1);
                        araddr  <= desc[grant].src;
                        awaddr  <= desc[grant].dst;
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (dma_m_miso_i.arready) begin
                        arvalid  <= 1'b0;
                        rready_q <= 1'b1;
                        rd_err   <= 1'b0;
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (fifo_push) begin
                        if (dma_m_miso_i.rresp != AXI_RESP_OKAY) begin
                            rd_err <= 1'b1;
                        end
                        if (dma_m_miso_i.rlast) begin
                            rready_q <= 1'b0;
                            if (rd_fail) begin
                                error_q[grant_q] <= 1'b1;
                                busy[grant_q]    <= 1'b0;
                                rr_ptr           <= rr_next;
                                state            <= ST_IDLE;
                            end else begin
                                awvalid <= 1'b1;
                                state   <= ST_AW;
                            end
                        end
                    end
                end
                ST_AW: begin
                    if (dma_m_miso_i.awready) begin
                        awvalid <= 1'b0;
                        wr_cnt  <= '0;
                        state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (fifo_pop) begin
                        wr_cnt <= wr_cnt + 9'd1;
                        if (wlast) begin
                            bready <= 1'b1;
                            state  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (dma_m_miso_i.bvalid) begin
                        bready <= 1'b0;
                        rr_ptr <= rr_next;
                        state  <= ST_IDLE;
                        if (dma_m_miso_i.bresp != AXI_RESP_OKAY) begin
                            error_q[grant_q] <= 1'b1;
                            busy[grant_q]    <= 1'b0;
                        end else begin
                            desc[grant_q].src       <= desc[grant_q].src + step;
                            desc[grant_q].dst       <= desc[grant_q].dst + step;
                            desc[grant_q].remaining <= desc[grant_q].remaining - step;
                            if (desc[grant_q].remaining == step) begin
                                done_q[grant_q] <= 1'b1;
                                busy[grant_q]   <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ch_busy_o  = busy;
    assign ch_done_o  = done_q;
    assign ch_error_o = error_q;

    always_comb begin
        dma_m_mosi_o         = '0;
        dma_m_mosi_o.arid    = axid;
        dma_m_mosi_o.araddr  = araddr;
        dma_m_mosi_o.arlen   = axlen;
        dma_m_mosi_o.arsize  = 3'(AXI_SIZE_LOG);
        dma_m_mosi_o.arburst = AXI_BURST_INCR;
        dma_m_mosi_o.arvalid = arvalid;
        dma_m_mosi_o.rready  = rready;
        dma_m_mosi_o.awid    = axid;
        dma_m_mosi_o.awaddr  = awaddr;
        dma_m_mosi_o.awlen   = axlen;
        dma_m_mosi_o.awsize  = 3'(AXI_SIZE_LOG);
        dma_m_mosi_o.awburst = AXI_BURST_INCR;
        dma_m_mosi_o.awvalid = awvalid;
        dma_m_mosi_o.wdata   = fifo_dout;
        dma_m_mosi_o.wstrb   = '1;
        dma_m_mosi_o.wlast   = wvalid & wlast;
        dma_m_mosi_o.wvalid  = wvalid;
        dma_m_mosi_o.bready  = bready;
    end

endmodule

// File: tb/tb_dma_axi_mchan.sv
// Directed bench for dma_axi_mchan with a small AXI4 slave memory model.
module tb_dma_axi_mchan;
    import dma_axi_mchan_pkg::*;

    localparam int unsigned NCH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH-1:0]        ch_start;
    axi_addr_t [NCH-1:0]   ch_src, ch_dst;
    logic [NCH-1:0][31:0]  ch_bytes;
    logic [NCH-1:0]        busy, done, error;
    s_axi_mosi_t           mosi;
    s_axi_miso_t           miso;

    dma_axi_mchan #(
        .NUM_CH(NCH),
        .MAX_BEATS(16),
        .FIFO_DEPTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_start_i  (ch_start),
        .ch_src_i    (ch_src),
        .ch_dst_i    (ch_dst),
        .ch_bytes_i  (ch_bytes),
        .ch_busy_o   (busy),
        .ch_done_o   (done),
        .ch_error_o  (error),
        .dma_m_mosi_o(mosi),
        .dma_m_miso_i(miso)
    );

    function automatic logic [63:0] pat(input int unsigned w);
        return {16'hC0DE, 16'(w), 32'(w * 32'h9E37_79B9)};
    endfunction

    // ---------------- slave memory model ----------------
    logic [63:0] mem [2048];
    logic        ar_rdy, aw_rdy, r_act, w_act, b_pend;
    axi_addr_t   r_addr, w_addr;
    logic [7:0]  r_len, r_beat, w_beat;
    axi_id_t     r_id, w_id;
    int          ar_num;
    int          inj_burst, inj_beat;
    logic [10:0] r_word, w_word;

    assign r_word = 11'((r_addr >> 3) + 32'(r_beat));
    assign w_word = 11'((w_addr >> 3) + 32'(w_beat));

    always_comb begin
        miso         = '0;
        miso.arready = ar_rdy;
        miso.awready = aw_rdy;
        miso.rvalid  = r_act;
        miso.rid     = r_id;
        miso.rdata   = mem[r_word];
        miso.rlast   = (r_beat == r_len);
        miso.rresp   = ((ar_num - 1) == inj_burst && int'(r_beat) == inj_beat) ? 2'b10 : 2'b00;
        miso.wready  = w_act;
        miso.bvalid  = b_pend;
        miso.bid     = w_id;
    end

    always @(posedge clk) begin
        if (rst) begin
            ar_rdy <= 1'b0; aw_rdy <= 1'b0; r_act <= 1'b0; w_act <= 1'b0; b_pend <= 1'b0;
            ar_num <= 0; r_beat <= '0; w_beat <= '0; r_len <= '0;
            r_addr <= '0; w_addr <= '0; r_id <= '0; w_id <= '0;
            for (int w = 0; w < 2048; w++) mem[w] <= pat(w);
        end else begin
            ar_rdy <= mosi.arvalid && !ar_rdy && !r_act;
            if (mosi.arvalid && ar_rdy) begin
                r_addr <= mosi.araddr; r_len <= mosi.arlen; r_id <= mosi.arid;
                r_beat <= '0; r_act <= 1'b1; ar_num <= ar_num + 1;
            end
            if (r_act && mosi.rready) begin
                r_beat <= r_beat + 8'd1;
                if (r_beat == r_len) r_act <= 1'b0;
            end
            aw_rdy <= mosi.awvalid && !aw_rdy && !w_act && !b_pend;
            if (mosi.awvalid && aw_rdy) begin
                w_addr <= mosi.awaddr; w_id <= mosi.awid; w_beat <= '0; w_act <= 1'b1;
            end
            if (w_act && mosi.wvalid) begin
                for (int b = 0; b < 8; b++)
                    if (mosi.wstrb[b]) mem[w_word][b*8 +: 8] <= mosi.wdata[b*8 +: 8];
                w_beat <= w_beat + 8'd1;
                if (mosi.wlast) begin
                    w_act <= 1'b0; b_pend <= 1'b1;
                end
            end
            if (b_pend && mosi.bready) b_pend <= 1'b0;
        end
    end

    // ---------------- monitor (sampled mid-cycle) ----------------
    int         done_cnt [NCH];
    int         err_cnt  [NCH];
    int         ar_ids[$], aw_ids[$];
    logic [7:0] ar_lens[$], ar_attr[$], aw_attr[$];
    axi_addr_t  ar_addrs[$];
    int         arv_cycles;

    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin done_cnt[c] = 0; err_cnt[c] = 0; end
            ar_ids.delete(); aw_ids.delete(); ar_lens.delete(); ar_addrs.delete();
            ar_attr.delete(); aw_attr.delete();
            arv_cycles = 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                done_cnt[c] += int'(done[c]);
                err_cnt[c]  += int'(error[c]);
            end
            if (mosi.arvalid) arv_cycles++;
            if (mosi.arvalid && miso.arready) begin
                ar_ids.push_back(int'(mosi.arid));
                ar_lens.push_back(mosi.arlen);
                ar_addrs.push_back(mosi.araddr);
                ar_attr.push_back({mosi.arsize, mosi.arburst, mosi.arlock, 2'b00});
            end
            if (mosi.awvalid && miso.awready) begin
                aw_ids.push_back(int'(mosi.awid));
                aw_attr.push_back({mosi.awsize, mosi.awburst, mosi.awlock, 2'b00});
            end
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mem_bad(input int src_w, input int dst_w, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (mem[dst_w + k] !== pat(src_w + k)) e++;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        ch_start = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int ch, input axi_addr_t s, input axi_addr_t d, input logic [31:0] n);
        ch_src[ch] = s; ch_dst[ch] = d; ch_bytes[ch] = n;
    endtask

    task automatic pulse(input logic [NCH-1:0] m);
        ch_start = m;
        @(posedge clk);
        #1 ch_start = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy != '0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, 64'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_exp2 [4];
        int n;
        ar_exp2  = '{0, 1, 0, 1};
        rst      = 1'b1;
        ch_start = '0;
        ch_src   = '0;
        ch_dst   = '0;
        ch_bytes = '0;
        inj_burst = -1;
        inj_beat  = 0;

        do_reset();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valids", 64'({mosi.arvalid, mosi.awvalid, mosi.wvalid, mosi.rready, mosi.bready}), 0);
        chk("rst_pulses", 64'({done, error}), 0);

        // 64 beats from ch0 -> four 16-beat bursts
        load(0, 32'h1000, 32'h2000, 32'd512);
        pulse(2'b01);
        chk("t1_busy_on", 64'(busy), 1);
        wait_idle("t1_timeout");
        chk("t1_nar", ar_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (ar_lens.size() > i) begin
                chk($sformatf("t1_arlen%0d", i), ar_lens[i], 15);
                chk($sformatf("t1_araddr%0d", i), ar_addrs[i], 32'h1000 + 128 * i);
                chk($sformatf("t1_arid%0d", i), ar_ids[i], 0);
            end
        end
        if (ar_attr.size() > 0) chk("t1_ar_attr", ar_attr[0], 8'h68);
        chk("t1_naw", aw_ids.size(), 4);
        if (aw_attr.size() > 0) chk("t1_aw_attr", aw_attr[0], 8'h68);
        chk("t1_data", mem_bad(32'h1000 / 8, 32'h2000 / 8, 64), 0);
        chk("t1_done", done_cnt[0], 1);
        chk("t1_err", err_cnt[0], 0);

        // two channels started together alternate burst by burst
        do_reset();
        load(0, 32'h1000, 32'h3000, 32'd256);
        load(1, 32'h1800, 32'h3800, 32'd256);
        pulse(2'b11);
        wait_idle("t2_timeout");
        chk("t2_nar", ar_ids.size(), 4);
        chk("t2_naw", aw_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (ar_ids.size() > i) chk($sformatf("t2_arid%0d", i), ar_ids[i], ar_exp2[i]);
            if (aw_ids.size() > i) chk($sformatf("t2_awid%0d", i), aw_ids[i], ar_exp2[i]);
        end
        if (ar_addrs.size() > 2) chk("t2_araddr2", ar_addrs[2], 32'h1080);
        chk("t2_data0", mem_bad(32'h1000 / 8, 32'h3000 / 8, 32), 0);
        chk("t2_data1", mem_bad(32'h1800 / 8, 32'h3800 / 8, 32), 0);
        chk("t2_done", 64'({done_cnt[1] == 1, done_cnt[0] == 1}), 3);

        // zero length and misaligned requests never touch the bus
        do_reset();
        load(0, 32'h1000, 32'h2000, 32'd0);
        pulse(2'b01);
        chk("t3_zero_done", 64'(done[0]), 1);
        chk("t3_zero_busy", 64'(busy), 0);
        @(posedge clk); #1;
        chk("t3_done_one_cycle", 64'(done[0]), 0);
        load(0, 32'h1000, 32'h2000, 32'd3);
        pulse(2'b01);
        chk("t3_len_err", 64'(error[0]), 1);
        chk("t3_len_busy", 64'(busy), 0);
        load(0, 32'h1004, 32'h2000, 32'd64);
        pulse(2'b01);
        chk("t3_addr_err", 64'(error[0]), 1);
        repeat (4) @(posedge clk); #1;
        chk("t3_no_arvalid", arv_cycles, 0);
        chk("t3_counts", 64'({done_cnt[0][7:0], err_cnt[0][7:0]}), 16'h0102);

        // read error in ch0's first burst: no write for it, ch1 still completes
        do_reset();
        inj_burst = 0;
        inj_beat  = 2;
        load(0, 32'h1000, 32'h3000, 32'd256);
        load(1, 32'h1800, 32'h3800, 32'd256);
        pulse(2'b11);
        wait_idle("t4_timeout");
        inj_burst = -1;
        chk("t4_nar", ar_ids.size(), 3);
        if (ar_ids.size() > 2) chk("t4_arids", 64'({ar_ids[0][3:0], ar_ids[1][3:0], ar_ids[2][3:0]}), 12'h011);
        chk("t4_naw", aw_ids.size(), 2);
        if (aw_ids.size() > 1) chk("t4_awids", 64'({aw_ids[0][3:0], aw_ids[1][3:0]}), 8'h11);
        chk("t4_ch0_err", err_cnt[0], 1);
        chk("t4_ch0_done", done_cnt[0], 0);
        chk("t4_ch1_done", done_cnt[1], 1);
        chk("t4_ch1_err", err_cnt[1], 0);
        chk("t4_ch1_data", mem_bad(32'h1800 / 8, 32'h3800 / 8, 32), 0);

        // transfer straddling a 4KB page
        do_reset();
        load(0, 32'h0FC0, 32'h2FC0, 32'd128);
        pulse(2'b01);
        wait_idle("t5_timeout");
`ifdef DMA_4K_SPLIT_EN
        chk("t5_nar", ar_ids.size(), 2);
        if (ar_lens.size() > 1) begin
            chk("t5_arlen0", ar_lens[0], 7);
            chk("t5_arlen1", ar_lens[1], 7);
            chk("t5_araddr1", ar_addrs[1], 32'h1000);
        end
`else
        chk("t5_nar", ar_ids.size(), 1);
        if (ar_lens.size() > 0) chk("t5_arlen0", ar_lens[0], 15);
`endif
        chk("t5_data", mem_bad(32'h0FC0 / 8, 32'h2FC0 / 8, 16), 0);
        chk("t5_done", done_cnt[0], 1);

        // reset in the middle of the write phase, then a clean transfer
        do_reset();
        load(0, 32'h1000, 32'h2000, 32'd256);
        pulse(2'b01);
        n = 0;
        while (!mosi.wvalid && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("t6_reached_wr", 64'(mosi.wvalid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valids", 64'({mosi.arvalid, mosi.awvalid, mosi.wvalid, mosi.rready, mosi.bready}), 0);
        chk("t6_busy", 64'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        load(1, 32'h1000, 32'h3000, 32'd256);
        pulse(2'b10);
        wait_idle("t6_timeout");
        chk("t6_done", done_cnt[1], 1);
        chk("t6_err", err_cnt[1], 0);
        chk("t6_data", mem_bad(32'h1000 / 8, 32'h3000 / 8, 32), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_axi_mchan.md
Name: dma_axi_mchan

Overview:
Multi-channel AXI4 memory-to-memory DMA engine. It is the parametrised successor of the single-channel DMA behind dma_axi_wrapper.
- NUM_CH independent copy channels share one AXI4 master port.
- Channels are arbitrated round-robin per burst.
- Each burst is read into an internal FIFO, then written out.
- Sits between the CSR front-end (which drives the per-channel descriptor inputs) and the system AXI interconnect.

Parameters:
NUM_CH, 2, number of copy channels (1..8)
MAX_BEATS, 16, maximum beats per AXI burst (power of 2, 1..256)
FIFO_DEPTH, 16, data buffer entries; must be >= MAX_BEATS

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_start_i  in  NUM_CH  per-channel start pulse
ch_src_i  in  NUM_CH x axi_addr_t  source byte address
ch_dst_i  in  NUM_CH x axi_addr_t  destination byte address
ch_bytes_i  in  NUM_CH x 32  transfer length in bytes
ch_busy_o  out  NUM_CH  channel active
ch_done_o  out  NUM_CH  one-cycle pulse on successful completion
ch_error_o  out  NUM_CH  one-cycle pulse on abort
dma_m_mosi_o  out  s_axi_mosi_t  AXI4 master request
dma_m_miso_i  in  s_axi_miso_t  AXI4 master response

Behaviour:
Reset:
- All valids/readies low; busy, done and error all 0.
- FSM returns to IDLE; FIFO is empty; round-robin pointer resets to channel 0.
- A reset mid-burst abandons the transaction. The AXI slave is reset in the same domain.

Channel start:
- ch_start_i is sampled only when the channel is idle; a start while busy is ignored.
- On start, src/dst/bytes are latched into per-channel registers.
- bytes == 0: done pulses the next cycle with no AXI traffic.
- bytes or either address not a multiple of the bus byte width (BW): error pulses the next cycle, channel stays idle.
- Otherwise busy = 1.

FSM:
- IDLE -> AR when any channel is busy. Grant the lowest busy index at or after rr_ptr.
- AR: arvalid until arready. arid = channel index, arlen = beats-1, arsize = log2(BW), arburst = INCR. lock/cache/prot/qos/region/user = 0.
- RD: rready = 1; each beat is pushed into the FIFO. Leave on rlast.
- AW: same field rules as AR, using dst; awvalid until awready.
- WR: wvalid while the FIFO is non-empty; wstrb all ones; wlast on the final beat. Leave on wlast & wready.
- B: bready = 1 until bvalid. Then update the channel: src += beats*BW, dst += beats*BW, remaining -= beats*BW.
- After B: remaining == 0 -> done pulse and busy clears. rr_ptr = grant + 1 (wraps modulo NUM_CH). Return to IDLE.

Burst sizing:
- beats = min(remaining/BW, MAX_BEATS, and the 4KB bound when the optional feature is enabled).

Errors:
- Any rresp or bresp != OKAY marks the burst failed.
- A failed read burst still drains the read data and skips the write phase (no AW/W).
- On failure: error pulse, busy clears, no done pulse.

Latency:
- Arbitration takes 1 cycle from IDLE to arvalid.
- Handshakes follow AXI rules: valid is never withdrawn before ready, and payload is held stable while valid.

Simultaneous events:
- A done/error pulse and a new start on the same channel in the same cycle: the new start is accepted, since the channel is idle from that cycle.

Optional Feature:
DMA_4K_SPLIT_EN:
- Defined: burst beats are also limited to (4096 - (addr mod 4096))/BW, computed on both src and dst (minimum of the two). No burst crosses a 4KB page.
- Undefined: this limit is removed, and software must guarantee page-safe transfers. Saves the comparator logic.

Decomposition:
- utils_pkg additions:
  - dma_st_t enum (IDLE, AR, RD, AW, WR, B)
  - dma_ch_desc_t struct (src, dst, remaining)
  - AXI_BW_BYTES constant derived from axi_data_t width
- Sub-module dma_fifo: synchronous FIFO, parametrised width/depth, with full/empty flags; reused by other blocks.

Test Plan:
1. Ch0 start, src=0x1000, dst=0x2000, bytes=64*BW, MAX_BEATS=16 -> four AR/AW bursts of arlen=15, destination matches source, one done pulse, busy low afterwards.
2. Ch0 and ch1 started in the same cycle, each 32*BW -> bursts alternate ch0, ch1, ch0, ch1 with arid/awid 0, 1, 0, 1; both done pulses asserted.
3. bytes=0 -> done pulses 1 cycle later with no arvalid; bytes=3 -> error pulse with no arvalid.
4. rresp=SLVERR on beat 2 of the first burst -> no awvalid for that burst, error pulse, no done pulse, other channel unaffected.
5. DMA_4K_SPLIT_EN defined, src=0xFC0, 16 beats with BW=8 -> first burst arlen=7, second arlen=7 at 0x1000.
6. Assert rst during WR -> next cycle all valids low and busy=0; a fresh transfer then completes normally.
